ccff_chain_loader: RTL and testbench

Initiator end of the configuration-chain protocol. Accepts bitstream words over a valid/ready stream and serialises them onto the chain input pin `ccff_head`, LSB first. It drives a clock-enable for the gated prog_clk that clocks the chain flip-flops. It also samples the chain's `ccff_tail` output to optionally verify the previously loaded contents. It sits at the fabric top, between the bitstream source (SoC bus or SPI bridge) and the first tile's chain head.

---
 rtl/ccff_pkg.sv | 22 ++
 rtl/ccff_chain_loader.sv | 124 ++++++++++++
 tb/tb_ccff_chain_loader.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ccff_pkg.sv
// Shared types and sizing helpers for the configuration-chain loader.
package ccff_pkg;

  // Loader FSM states.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_WORD = 2'd1,
    ST_SHIFT     = 2'd2,
    ST_DONE      = 2'd3
  } ccff_state_t;

  // Width needed to count 0..chain_len shifted bits inclusive.
  function automatic int cnt_width(input int chain_len);
    return $clog2(chain_len + 1);
  endfunction

  // Width of the bit index within one bitstream word (at least 1).
  function automatic int idx_width(input int data_w);
    return (data_w > 1) ? $clog2(data_w) : 1;
  endfunction

endpackage

// File: rtl/ccff_chain_loader.sv
// Initiator of the configuration chain: takes bitstream words over a
// valid/ready stream, shifts them LSB first onto ccff_head while enabling the
// chain clock gate, and optionally checks ccff_tail against the bits going in.
module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 1024,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = cnt_width(CHAIN_LEN)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              abort,
  input  logic              verify_en,
  input  logic [DATA_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              chain_clk_en,
  output logic              busy,
  output logic              done,
  output logic              mismatch,
  output logic [CNT_W-1:0]  bit_count
);

  localparam int IDX_W = idx_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  ccff_state_t       state_reg;
  logic [DATA_W-1:0] shreg_reg;
  logic [DATA_W-1:0] shreg_shifted;
  logic [IDX_W-1:0]  idx_reg;
  logic [CNT_W-1:0]  bit_count_reg;
  logic              verify_reg;
  logic              mismatch_reg;
  logic              clk_en_reg;
  logic              head_reg;
  logic              done_reg;

  assign shreg_shifted = shreg_reg >> 1;

  // Loader FSM. The clock enable, head bit and done pulse are flops of their
  // own (not state decodes) so the external clock gate never sees a glitch
  // while the two state bits change together.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state_reg     <= ST_IDLE;
      shreg_reg     <= '0;
      idx_reg       <= '0;
      bit_count_reg <= '0;
      verify_reg    <= 1'b0;
      mismatch_reg  <= 1'b0;
      clk_en_reg    <= 1'b0;
      head_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      clk_en_reg <= 1'b0;
      head_reg   <= 1'b0;
      done_reg   <= 1'b0;
      if (abort && (state_reg != ST_IDLE)) begin
        // Abort wins over everything else; the partial count is kept.
        state_reg <= ST_IDLE;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (start) begin
              state_reg     <= ST_WAIT_WORD;
              bit_count_reg <= '0;
              mismatch_reg  <= 1'b0;
              verify_reg    <= verify_en;
            end
          end
          ST_WAIT_WORD: begin
            if (bs_valid) begin
              shreg_reg  <= bs_data;
              idx_reg    <= '0;
              state_reg  <= ST_SHIFT;
              clk_en_reg <= 1'b1;
              head_reg   <= bs_data[0];
            end
          end
          ST_SHIFT: begin
            shreg_reg     <= shreg_shifted;
            idx_reg       <= idx_reg + IDX_W'(1);
            bit_count_reg <= bit_count_reg + CNT_W'(1);
            // On a reload of the same image the tail shows old bit k while
            // new bit k goes in, so any difference means the images differ.
            if (verify_reg && (ccff_tail != head_reg)) begin
              mismatch_reg <= 1'b1;
            end
            if (bit_count_reg == LAST_BIT) begin
              // Chain full: any unused high bits of this word are dropped.
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else if (idx_reg == LAST_IDX) begin
              state_reg <= ST_WAIT_WORD;
            end else begin
              clk_en_reg <= 1'b1;
              head_reg   <= shreg_shifted[0];
            end
          end
          ST_DONE: begin
            state_reg <= ST_IDLE;
          end
          default: begin
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bs_ready     = (state_reg == ST_WAIT_WORD);
  assign busy         = (state_reg != ST_IDLE);
  assign chain_clk_en = clk_en_reg;
  assign ccff_head    = head_reg;
  assign done         = done_reg;
  assign mismatch     = mismatch_reg;
  assign bit_count    = bit_count_reg;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader with behavioural chain models
// (40-bit and 64-bit) clocked through chain_clk_en.
module tb_ccff_chain_loader;

  logic        prog_clk = 1'b0;
  logic        prog_reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        verify_en = 1'b0;
  logic [31:0] bs_data = '0;
  logic        bs_valid = 1'b0;
  logic        bs_ready, ccff_head, ccff_tail, chain_clk_en, busy, done, mismatch;
  logic [5:0]  bit_count;

  logic        start64 = 1'b0;
  logic [31:0] bs_data64 = '0;
  logic        bs_valid64 = 1'b0;
  logic        bs_ready64, ccff_head64, ccff_tail64, chain_clk_en64, busy64, done64, mismatch64;
  logic [6:0]  bit_count64;

  logic [39:0] chain40 = '0;
  logic [63:0] chain64 = '0;

  int checks = 0;
  int failures = 0;

  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader #(.CHAIN_LEN(40), .DATA_W(32)) dut (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start), .abort(abort),
    .verify_en(verify_en), .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(bs_ready),
    .ccff_head(ccff_head), .ccff_tail(ccff_tail), .chain_clk_en(chain_clk_en),
    .busy(busy), .done(done), .mismatch(mismatch), .bit_count(bit_count)
  );

  ccff_chain_loader #(.CHAIN_LEN(64), .DATA_W(32)) dut64 (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start64), .abort(abort),
    .verify_en(verify_en), .bs_data(bs_data64), .bs_valid(bs_valid64), .bs_ready(bs_ready64),
    .ccff_head(ccff_head64), .ccff_tail(ccff_tail64), .chain_clk_en(chain_clk_en64),
    .busy(busy64), .done(done64), .mismatch(mismatch64), .bit_count(bit_count64)
  );

  // Chain models: index 0 is the tail, new bits enter at the top.
  always @(posedge prog_clk) begin
    if (chain_clk_en) chain40 <= {ccff_head, chain40[39:1]};
    if (chain_clk_en64) chain64 <= {ccff_head64, chain64[63:1]};
  end
  assign ccff_tail   = chain40[0];
  assign ccff_tail64 = chain64[0];

  typedef struct packed {
    logic        start;
    logic        valid;
    logic [31:0] data;
    logic        st;     // status (bit_count/mismatch) is defined this cycle
    logic        ready;
    logic        en;
    logic        done;
    logic        busy;
    logic        head;
    logic        mm;
    logic [5:0]  bc;
  } vec_t;

  vec_t tbl [64];
  int   tbl_len;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  // Expected per-cycle behaviour of a two-word, 40-bit load with the second
  // word delayed by 'gap' cycles; mismatch expected from the edge after mm_cycle.
  task automatic build(input logic [31:0] w0, input logic [31:0] w1, input int gap, input int mm_cycle);
    tbl_len = 45 + gap;
    for (int c = 0; c < tbl_len; c++) begin
      int bc;
      vec_t v;
      v = '0;
      v.start = (c == 0);
      v.valid = (c == 1) || (c >= 34 + gap);
      v.data  = (c < 34) ? w0 : w1;
      v.st    = (c >= 1);
      v.ready = (c == 1) || (c >= 34 && c <= 34 + gap);
      v.en    = (c >= 2 && c <= 33) || (c >= 35 + gap && c <= 42 + gap);
      v.done  = (c == 43 + gap);
      v.busy  = (c >= 1 && c <= 43 + gap);
      if (c >= 2 && c <= 33) v.head = w0[c-2];
      else if (v.en) v.head = w1[c-35-gap];
      v.mm = (mm_cycle >= 0) && (c > mm_cycle);
      if (c <= 2) bc = 0;
      else if (c <= 34) bc = c - 2;
      else if (c <= 35 + gap) bc = 32;
      else if (c - 3 - gap > 40) bc = 40;
      else bc = c - 3 - gap;
      v.bc = 6'(bc);
      tbl[c] = v;
    end
  endtask

  task automatic apply(input logic ver, input string tag);
    verify_en = ver;
    for (int c = 0; c < tbl_len; c++) begin
      start    = tbl[c].start;
      bs_valid = tbl[c].valid;
      bs_data  = tbl[c].data;
      chk($sformatf("%s c%0d bs_ready", tag, c), bs_ready, tbl[c].ready);
      chk($sformatf("%s c%0d chain_clk_en", tag, c), chain_clk_en, tbl[c].en);
      chk($sformatf("%s c%0d done", tag, c), done, tbl[c].done);
      chk($sformatf("%s c%0d busy", tag, c), busy, tbl[c].busy);
      chk($sformatf("%s c%0d ccff_head", tag, c), ccff_head, tbl[c].head);
      if (tbl[c].st) begin
        chk($sformatf("%s c%0d bit_count", tag, c), bit_count, tbl[c].bc);
        chk($sformatf("%s c%0d mismatch", tag, c), mismatch, tbl[c].mm);
      end
      tick();
    end
    start    = 1'b0;
    bs_valid = 1'b0;
    $display("load %s: bit_count=%0d mismatch=%0b chain=%h", tag, bit_count, mismatch, chain40);
  endtask

  initial begin
    // Reset state
    #2;
    chk("reset bs_ready", bs_ready, 0);
    chk("reset ccff_head", ccff_head, 0);
    chk("reset chain_clk_en", chain_clk_en, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset mismatch", mismatch, 0);
    chk("reset bit_count", bit_count, 0);
    repeat (2) @(posedge prog_clk);
    #1 prog_reset = 1'b0;
    tick();

    // 1: plain two-word load
    build(32'hDEADBEEF, 32'h000000A5, 0, -1);
    apply(1'b0, "t1");
    chk("t1 chain", chain40, 40'hA5DEADBEEF);

    // 2: identical reload with verify, then a one-bit-different reload
    build(32'hDEADBEEF, 32'h000000A5, 0, -1);
    apply(1'b1, "t2a");
    build(32'hDEADBEEF, 32'h000000A4, 0, 35);
    apply(1'b1, "t2b");
    chk("t2b chain", chain40, 40'hA4DEADBEEF);

    // 3: second word withheld 10 cycles
    build(32'hDEADBEEF, 32'h000000A5, 10, -1);
    apply(1'b0, "t3");
    chk("t3 chain", chain40, 40'hA5DEADBEEF);

    // 4: abort at c20
    verify_en = 1'b0;
    bs_valid  = 1'b1;
    bs_data   = 32'h12345678;
    for (int c = 0; c < 20; c++) begin
      start = (c == 0);
      tick();
    end
    start = 1'b0;
    abort = 1'b1;
    chk("t4 c20 chain_clk_en", chain_clk_en, 1);
    chk("t4 c20 bit_count", bit_count, 18);
    tick();
    abort    = 1'b0;
    bs_valid = 1'b0;
    chk("t4 c21 busy", busy, 0);
    chk("t4 c21 chain_clk_en", chain_clk_en, 0);
    chk("t4 c21 ccff_head", ccff_head, 0);
    chk("t4 c21 bs_ready", bs_ready, 0);
    chk("t4 c21 bit_count", bit_count, 18);
    for (int c = 22; c < 27; c++) begin
      chk($sformatf("t4 c%0d done", c), done, 0);
      tick();
    end
    $display("load t4abort: bit_count=%0d", bit_count);
    build(32'hDEADBEEF, 32'h000000A5, 0, -1);
    apply(1'b0, "t4reload");
    chk("t4 chain", chain40, 40'hA5DEADBEEF);

    // 5: start ignored during SHIFT, then asynchronous reset mid-load
    verify_en = 1'b1;
    bs_valid  = 1'b1;
    bs_data   = 32'hDEADBEEE;
    for (int c = 0; c < 10; c++) begin
      start = (c == 0);
      tick();
    end
    start = 1'b1;
    chk("t5 c10 bit_count", bit_count, 8);
    tick();
    start = 1'b0;
    chk("t5 c11 busy", busy, 1);
    chk("t5 c11 chain_clk_en", chain_clk_en, 1);
    chk("t5 c11 bit_count", bit_count, 9);
    chk("t5 c11 mismatch", mismatch, 1);
    repeat (4) tick();
    chk("t5 c15 bit_count", bit_count, 13);
    #2 prog_reset = 1'b1;
    #1;
    chk("t5 rst bs_ready", bs_ready, 0);
    chk("t5 rst ccff_head", ccff_head, 0);
    chk("t5 rst chain_clk_en", chain_clk_en, 0);
    chk("t5 rst busy", busy, 0);
    chk("t5 rst done", done, 0);
    chk("t5 rst mismatch", mismatch, 0);
    chk("t5 rst bit_count", bit_count, 0);
    @(negedge prog_clk);
    prog_reset = 1'b0;
    bs_valid   = 1'b0;
    verify_en  = 1'b0;
    tick();
    chk("t5 after busy", busy, 0);
    $display("load t5reset: bit_count=%0d busy=%0b", bit_count, busy);

    // 6: 64-bit chain, exactly two words
    bs_valid64 = 1'b1;
    for (int c = 0; c < 71; c++) begin
      start64   = (c == 0);
      bs_data64 = (c <= 1) ? 32'h01234567 : 32'h89ABCDEF;
      chk($sformatf("t6 c%0d bs_ready", c), bs_ready64, (c == 1) || (c == 34));
      chk($sformatf("t6 c%0d chain_clk_en", c), chain_clk_en64,
          (c >= 2 && c <= 33) || (c >= 35 && c <= 66));
      chk($sformatf("t6 c%0d done", c), done64, (c == 67));
      tick();
    end
    start64    = 1'b0;
    bs_valid64 = 1'b0;
    chk("t6 bit_count", bit_count64, 64);
    chk("t6 busy", busy64, 0);
    chk("t6 chain", chain64, 64'h89ABCDEF01234567);
    $display("load t6: bit_count=%0d chain=%h", bit_count64, chain64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
